// File: rtl/fpmul_arbiter.sv
// Round-robin issue arbiter sharing one pipelined FP32 multiplier among NREQ clients.
// Define FPMUL_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fpmul_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    input  logic [31:0]        mul_c,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_c,
    output logic               busy
);

    localparam int NST = MUL_LAT + 1;

    logic [31:0]    op_a [NREQ];
    logic [31:0]    op_b [NREQ];

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [31:0]    mul_a_q, mul_a_d;
    logic [31:0]    mul_b_q, mul_b_d;
    logic [NST-1:0] tag_v_q, tag_v_d;
    logic [IDW-1:0] tag_id_q [NST];
    logic [IDW-1:0] tag_id_d [NST];
    logic           busy_q, busy_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            found;
    logic            accept;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign op_a[i] = req_a[32*i +: 32];
        assign op_b[i] = req_b[32*i +: 32];
    end

    // Search starts at ptr and wraps; the first valid index found wins.
    always_comb begin
        int j;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid[j]) begin
                found  = 1'b1;
                gnt_id = IDW'(j);
            end
        end
        if (found && en && !rst) gnt[gnt_id] = 1'b1;
    end

    assign accept = |gnt;

    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        ptr_d   = ptr_q;
        if (accept) begin
            mul_a_d = op_a[gnt_id];
            mul_b_d = op_b[gnt_id];
`ifdef FPMUL_ARB_FIXED_PRIO_EN
            ptr_d = '0;
`else
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`endif
        end
    end

    // Idle cycles shift in an invalid tag with id 0 so rsp_id stays clean.
    always_comb begin
        tag_v_d[0]  = accept;
        tag_id_d[0] = accept ? gnt_id : '0;
        for (int s = 1; s < NST; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end
        busy_d = |tag_v_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            tag_v_q <= '0;
            busy_q  <= 1'b0;
            for (int s = 0; s < NST; s++) tag_id_q[s] <= '0;
        end else begin
            ptr_q   <= ptr_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            tag_v_q <= tag_v_d;
            busy_q  <= busy_d;
            for (int s = 0; s < NST; s++) tag_id_q[s] <= tag_id_d[s];
        end
    end

    assign req_ready = gnt;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = tag_v_q[NST-1];
    assign rsp_id    = tag_id_q[NST-1];
    assign rsp_c     = mul_c;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_fpmul_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int MUL_LAT = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic [31:0]        mul_c;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_c;
    logic               busy;

    fpmul_arbiter #(.NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural FP32 multiply via double precision; exact for the values used in directed tests.
    function automatic real f2r(input logic [31:0] a);
        logic [63:0] d;
        if (a[30:23] == 8'h00)      d = {a[31], 63'h0};
        else if (a[30:23] == 8'hFF) d = {a[31], 11'h7FF, a[22:0], 29'h0};
        else                        d = {a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        real p;
        logic [63:0] d;
        int e;
        p = f2r(a) * f2r(b);
        d = $realtobits(p);
        if (d[62:52] == 11'h7FF) return (d[51:0] != 0) ? {d[63], 8'hFF, 23'h400000} : {d[63], 8'hFF, 23'h0};
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        if (e <= 0)   return {d[63], 31'h0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    logic [31:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int s = 1; s < MUL_LAT; s++) mpipe[s] <= mpipe[s-1];
    end
    assign mul_c = mpipe[MUL_LAT-1];

    typedef struct {
        int          id;
        logic [31:0] c;
        int          due;
    } pend_t;

    pend_t       q[$];
    int          grant_log[$];
    int          rsp_id_log[$];
    logic [31:0] rsp_c_log[$];
    int          rsp_cyc_log[$];

    int            nvec = 0;
    int            nerr = 0;
    int            cyc = 0;
    int            m_ptr = 0;
    logic [31:0]   m_a = '0;
    logic [31:0]   m_b = '0;
    int            acc_id = -1;
    logic [NREQ-1:0] last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // One clock cycle: check DUT against the model at the falling edge, then advance the model.
    task automatic step();
        logic [NREQ-1:0] er;
        int g;
        @(negedge clk);
        if (rst) begin
            q.delete();
            m_a   = '0;
            m_b   = '0;
            m_ptr = 0;
        end
        er = '0;
        g  = -1;
        if (!rst && en) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("mul_a", mul_a, m_a);
        chk("mul_b", mul_b, m_b);
        if (rst) chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_c", rsp_c, q[0].c);
            rsp_id_log.push_back(int'(rsp_id));
            rsp_c_log.push_back(rsp_c);
            rsp_cyc_log.push_back(cyc);
            void'(q.pop_front());
        end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'd0);
        end
        last_ready = req_ready;
        acc_id     = g;
        if (g >= 0) begin
            q.push_back('{g, fmul(req_a[32*g +: 32], req_b[32*g +: 32]), cyc + MUL_LAT + 1});
            m_a = req_a[32*g +: 32];
            m_b = req_b[32*g +: 32];
`ifdef FPMUL_ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (g + 1) % NREQ;
`endif
            grant_log.push_back(g);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int kc;
        rst       = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Single request from requester 1
        en = 1'b1;
        set_op(1, 32'h40000000, 32'h447A0000);
        req_valid = 4'b0010;
        kc = cyc;
        step();
        chk("single_ready", 32'(last_ready), 32'h2);
        rsp_cyc_log.delete(); rsp_id_log.delete(); rsp_c_log.delete();
        drain(3);
        chk("single_nrsp", 32'(rsp_cyc_log.size()), 32'd1);
        if (rsp_cyc_log.size() == 1) begin
            chk("single_lat", 32'(rsp_cyc_log[0]), 32'(kc + 2));
            chk("single_id", 32'(rsp_id_log[0]), 32'd1);
            chk("single_c", rsp_c_log[0], 32'h44FA0000);
        end

        // All four requesters valid for 8 cycles
        apply_reset();
        grant_log.delete(); rsp_id_log.delete();
        for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            step();
            if (acc_id >= 0) set_op(acc_id, $urandom, $urandom);
        end
        drain(3);
        chk("rr_ngrant", 32'(grant_log.size()), 32'd8);
        chk("rr_nrsp", 32'(rsp_id_log.size()), 32'd8);
        for (int n = 0; n < 8 && n < grant_log.size() && n < rsp_id_log.size(); n++) begin
`ifdef FPMUL_ARB_FIXED_PRIO_EN
            chk("rr_grant", 32'(grant_log[n]), 32'd0);
            chk("rr_rspid", 32'(rsp_id_log[n]), 32'd0);
`else
            chk("rr_grant", 32'(grant_log[n]), 32'(n % NREQ));
            chk("rr_rspid", 32'(rsp_id_log[n]), 32'(n % NREQ));
`endif
        end

        // Special values pass through bit-exact
        rsp_id_log.delete(); rsp_c_log.delete(); rsp_cyc_log.delete();
        set_op(2, 32'h7F800000, 32'h01810000);
        req_valid = 4'b0100;
        step();
        set_op(3, 32'h41200000, 32'hC2C60000);
        req_valid = 4'b1000;
        step();
        drain(3);
        chk("spec_nrsp", 32'(rsp_id_log.size()), 32'd2);
        if (rsp_id_log.size() == 2) begin
            chk("spec_id0", 32'(rsp_id_log[0]), 32'd2);
            chk("spec_c0", rsp_c_log[0], 32'h7F800000);
            chk("spec_id1", 32'(rsp_id_log[1]), 32'd3);
            chk("spec_c1", rsp_c_log[1], 32'hC4778000);
            chk("spec_b2b", 32'(rsp_cyc_log[1] - rsp_cyc_log[0]), 32'd1);
        end

        // en gating
        rsp_cyc_log.delete();
        set_op(0, 32'h3F800000, 32'h40400000);
        req_valid = 4'b0001;
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("en_low_ready", 32'(last_ready), 32'd0);
        end
        chk("en_low_nrsp", 32'(rsp_cyc_log.size()), 32'd0);
        en = 1'b1;
        kc = cyc;
        step();
        chk("en_rise_ready", 32'(last_ready), 32'd1);
        drain(3);
        chk("en_nrsp", 32'(rsp_cyc_log.size()), 32'd1);
        if (rsp_cyc_log.size() == 1) chk("en_lat", 32'(rsp_cyc_log[0]), 32'(kc + 2));

        // Reset with two operations in flight
        rsp_cyc_log.delete();
        set_op(1, 32'h40A00000, 32'h40A00000);
        set_op(2, 32'h40C00000, 32'h40C00000);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0100;
        step();
        req_valid = 4'b1010;
        rst = 1'b1;
        step();
        chk("mf_rst_busy", 32'(busy), 32'd0);
        chk("mf_rst_mula", mul_a, 32'd0);
        chk("mf_rst_mulb", mul_b, 32'd0);
        rst = 1'b0;
        step();
        chk("mf_first_grant", 32'(last_ready), 32'h2);
        drain(4);
        chk("mf_nrsp", 32'(rsp_cyc_log.size()), 32'd1);

        // Random traffic
        req_valid = '0;
        acc_id = -1;
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || acc_id == i) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    set_op(i, $urandom, $urandom);
                end
            end
            step();
        end
        drain(4);
        chk("end_queue_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fpmul_arbiter.md
# fpmul_arbiter

- Shares one clocked IEEE 754 single-precision multiplier among `NREQ` requesters.
- Arbitrates issue with a valid/ready handshake, at most one multiply per cycle.
- Drives the multiplier's operand inputs and tags every issued operation with its requester ID.
- Returns each product with that ID once the multiplier's fixed latency has elapsed.
- Sits between the FP multiplier datapath and its clients, so several producers can share a single multiplier instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, 2: requester ID width, equal to clog2(`NREQ`).
- `MUL_LAT`, 1: multiplier latency in cycles, from registered operands to valid `mul_c`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: issue enable. When low, no grants are made; in-flight operations still complete.
- `req_valid` in `NREQ`: per-requester request.
- `req_a` in 32*`NREQ`: operand A. Requester i uses bits [32i+31:32i].
- `req_b` in 32*`NREQ`: operand B, same packing as `req_a`.
- `req_ready` out `NREQ`: one-hot grant, combinational.
- `mul_a` out 32: registered operand A to the multiplier.
- `mul_b` out 32: registered operand B to the multiplier.
- `mul_c` in 32: multiplier product.
- `rsp_valid` out 1: product valid, one-cycle pulse per issued operation.
- `rsp_id` out `IDW`: requester ID of the current response.
- `rsp_c` out 32: product. Equals `mul_c` while `rsp_valid` is high.
- `busy` out 1: at least one operation is in flight.

## Operation
- **Grant rule.** `req_ready[i]` = `en` & `req_valid[i]` & (i is the first valid index at or after `ptr`, cyclically).
  - At most one bit of `req_ready` is high.
  - `req_ready` is all zero while `rst` is high.
- **Handshake.** Requester i is accepted in cycle k when `req_valid[i]` and `req_ready[i]` are both high in cycle k.
  - A requester holds `req_valid` and its operands stable until accepted.
  - No combinational path runs from `req_ready` to `req_valid`.
- **On accept of i:**
  - `mul_a`/`mul_b` load i's operands and hold them until the next accept.
  - `ptr` becomes (i+1) mod `NREQ`.
  - A tag {valid=1, id=i} enters the tag shift register, which is `MUL_LAT`+1 stages deep.
- **Idle cycles.** A cycle with no accept shifts in tag valid=0. `mul_a`/`mul_b` are unchanged.
- **Response.** `rsp_valid`/`rsp_id` are the last tag stage. `rsp_c` = `mul_c`.
  - No response backpressure: the consumer accepts every response.
- **Numerics.** The arbiter does no arithmetic. NaN, Inf and zero handling belong entirely to the multiplier, and products pass through bit-exact.
- **`busy`** = OR of all tag valid bits.
- **Reset values:**
  - `mul_a`, `mul_b` = 0.
  - `ptr` = 0.
  - All tags invalid, so `rsp_valid` = 0, `rsp_id` = 0, `busy` = 0.
- **Reset mid-operation.** In-flight operations are dropped with no response. The first accept after reset is the lowest valid index.
- **Simultaneous requests.** Round-robin from `ptr`. A requester that stays valid is granted within `NREQ` accepts.
- **`en` low with requests pending.** No accept occurs and `ptr` holds. Responses for earlier accepts still appear on schedule.

## Timing
- Throughput: one accept per cycle when continuously requested.
- Latency: an accept in cycle k gives `rsp_valid` in cycle k+`MUL_LAT`+1. With the default `MUL_LAT` = 1, that is cycle k+2.
- Responses return in accept order. Back-to-back accepts give back-to-back responses.
- `req_ready` is combinational from `req_valid`, `en`, `ptr` and `rst`. All other outputs are registered, except `rsp_c`, which is a pass-through of `mul_c`.

## Configuration
- Macro: `FPMUL_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority. The lowest valid index always wins, and `ptr` is held at 0 and never updated.
- **Undefined (default):** round-robin, as described in Operation.
- Latency, handshake and reset behaviour are identical in both modes.

## Test plan
- **Single request.** Reset, then requester 1 presents a=0x40000000 (2.0), b=0x447A0000 (1000.0) with `en`=1. Expected:
  - `req_ready`=0010 the same cycle.
  - `rsp_valid`=1, `rsp_id`=1, `rsp_c`=0x44FA0000 (2000.0) exactly 2 cycles after the accept, for one cycle.
- **All four requesters valid every cycle for 8 cycles.** Expected:
  - Grant order 0,1,2,3,0,1,2,3, one per cycle.
  - `rsp_id` follows the same order, 2 cycles later.
  - Under `FPMUL_ARB_FIXED_PRIO_EN`, requester 0 is granted all 8 cycles.
- **Special values.** Requester 2 issues 0x7F800000 × 0x01810000, then requester 3 issues 0x41200000 × 0xC2C60000 in the next cycle. Expected:
  - Consecutive responses {id=2, 0x7F800000}, then {id=3, 0xC4778000} (-990.0).
- **`en` gating.** Requester 0 is valid throughout. Hold `en`=0 for 5 cycles.
  - Expected while `en`=0: `req_ready`=0 and no new responses.
  - Expected after `en` rises: accept in that same cycle, response 2 cycles later.
- **Reset mid-flight.** Accept two operations, then assert `rst` for 1 cycle before their responses would appear. Expected:
  - No `rsp_valid` from the dropped operations.
  - `busy`=0 and `mul_a`=`mul_b`=0 during reset.
  - The next grant goes to the lowest valid index.
